// File: rtl/ahb_lite_initiator.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ word transfers.
// Optional data-phase timeout with lock-up is enabled by defining AHB_INITIATOR_TIMEOUT_EN.
module ahb_lite_initiator #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef AHB_INITIATOR_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  logic              ap_valid_q, ap_valid_d;
  logic              ap_write_q, ap_write_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              cancel_q, cancel_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              locked;
  logic              issue, accept, advance, complete;

`ifdef AHB_INITIATOR_TIMEOUT_EN
  typedef enum logic {StRun, StLocked} state_e;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  assign locked  = (state_q == StLocked);
  assign timeout = locked;
`else
  assign locked = 1'b0;
`endif

  // cancel_q marks the second error cycle, where the address phase is withdrawn from the bus
  assign issue     = ap_valid_q && !cancel_q && !locked;
  assign cmd_ready = !locked && (!ap_valid_q || (HREADY && !HRESP && !cancel_q));
  assign accept    = cmd_valid && cmd_ready;
  assign advance   = issue && HREADY;
  assign complete  = dp_valid_q && HREADY;

  assign HTRANS    = issue ? TransNonseq : TransIdle;
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = 3'b010;
  assign HWDATA    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cancel_d    = cancel_q;
`ifdef AHB_INITIATOR_TIMEOUT_EN
    state_d     = state_q;
    wait_cnt_d  = '0;
`endif

    if (HREADY) begin
      cancel_d = 1'b0;
    end else if (dp_valid_q && HRESP) begin
      cancel_d = 1'b1;
    end

    if (complete) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = dp_write_q ? '0 : HRDATA;
      rsp_err_d   = HRESP;
      dp_valid_d  = 1'b0;
    end

    if (advance) begin
      dp_valid_d = 1'b1;
      dp_write_d = ap_write_q;
      ap_valid_d = 1'b0;
      if (ap_write_q) begin
        dp_wdata_d = ap_wdata_q;
      end
    end

    if (accept) begin
      ap_valid_d = 1'b1;
      ap_write_d = cmd_write;
      ap_addr_d  = cmd_addr;
      ap_wdata_d = cmd_wdata;
    end

`ifdef AHB_INITIATOR_TIMEOUT_EN
    if (dp_valid_q && !HREADY && !locked) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        dp_valid_d  = 1'b0;
        ap_valid_d  = 1'b0;
        cancel_d    = 1'b0;
        wait_cnt_d  = '0;
        state_d     = StLocked;
      end
    end
    if (locked) begin
      ap_valid_d = 1'b0;
      dp_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      cancel_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef AHB_INITIATOR_TIMEOUT_EN
      state_q     <= StRun;
      wait_cnt_q  <= '0;
`endif
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      cancel_q    <= cancel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef AHB_INITIATOR_TIMEOUT_EN
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed bench for ahb_lite_initiator: scripted slave, response scoreboard, HRESP protocol watch.
// Define AHB_INITIATOR_TIMEOUT_EN to also exercise the timeout lock-up.
module tb_ahb_lite_initiator;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HREADY, HRESP;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA, HRDATA;
`ifdef AHB_INITIATOR_TIMEOUT_EN
  logic          timeout;
`endif

  ahb_lite_initiator #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
`ifdef AHB_INITIATOR_TIMEOUT_EN
    .timeout  (timeout),
`endif
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HRDATA   (HRDATA),
    .HRESP    (HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];  // {err, rdata}
  logic [DW:0] exp_e;
  logic        dp_tb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic cmd(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic bus(input logic rdy, input logic resp, input logic [DW-1:0] rd);
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = rd;
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b required no response", rsp_rdata,
                 rsp_err);
      end else begin
        exp_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp_e[DW-1:0]);
        check("rsp_err", 32'(rsp_err), 32'(exp_e[DW]));
      end
    end
  end

  // Slave-side protocol watch: ERROR is only legal while a data phase is in flight
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_tb <= 1'b0;
    else if (HREADY) dp_tb <= (HTRANS == 2'b10);
  end

  always @(negedge HCLK) begin
    if (HRESETn && HRESP) check("hresp_with_dp_empty", 32'(dp_tb), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    cmd(1'b0, 1'b0, '0, '0);
    bus(1'b1, 1'b0, '0);
    repeat (2) @(posedge HCLK);
    smp();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h2);
    check("rst_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    cyc();
    HRESETn = 1'b1;

    // Single write
    cmd(1'b1, 1'b1, 32'h4, 32'h1);
    exp_q.push_back({1'b0, 32'h0});
    smp();
    check("w1_cmd_ready", 32'(cmd_ready), 32'h1);
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    smp();
    check("w1_htrans", 32'(HTRANS), 32'h2);
    check("w1_hwrite", 32'(HWRITE), 32'h1);
    check("w1_haddr", HADDR, 32'h4);
    check("w1_rsp_early", 32'(rsp_valid), 32'h0);
    cyc();
    smp();
    check("w1_idle", 32'(HTRANS), 32'h0);
    check("w1_hwdata", HWDATA, 32'h1);
    check("w1_rsp_early2", 32'(rsp_valid), 32'h0);
    cyc();
    smp();
    check("w1_rsp_valid", 32'(rsp_valid), 32'h1);

    // Three back-to-back reads
    cyc();
    cmd(1'b1, 1'b0, 32'h0, '0);
    exp_q.push_back({1'b0, 32'h0000A5A5});
    smp();
    cyc();
    cmd(1'b1, 1'b0, 32'h4, '0);
    exp_q.push_back({1'b0, 32'h00000001});
    smp();
    check("r3_htrans0", 32'(HTRANS), 32'h2);
    check("r3_haddr0", HADDR, 32'h0);
    check("r3_ready0", 32'(cmd_ready), 32'h1);
    cyc();
    cmd(1'b1, 1'b0, 32'h8, '0);
    bus(1'b1, 1'b0, 32'h0000A5A5);
    exp_q.push_back({1'b0, 32'h00001234});
    smp();
    check("r3_htrans1", 32'(HTRANS), 32'h2);
    check("r3_haddr1", HADDR, 32'h4);
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    bus(1'b1, 1'b0, 32'h00000001);
    smp();
    check("r3_htrans2", 32'(HTRANS), 32'h2);
    check("r3_haddr2", HADDR, 32'h8);
    check("r3_rsp0", 32'(rsp_valid), 32'h1);
    cyc();
    bus(1'b1, 1'b0, 32'h00001234);
    smp();
    check("r3_idle", 32'(HTRANS), 32'h0);
    check("r3_rsp1", 32'(rsp_valid), 32'h1);
    cyc();
    bus(1'b1, 1'b0, 32'h0);
    smp();
    check("r3_rsp2", 32'(rsp_valid), 32'h1);
    cyc();
    smp();
    check("r3_rsp_done", 32'(rsp_valid), 32'h0);

    // Read with three wait states, write queued behind it
    cyc();
    cmd(1'b1, 1'b0, 32'h20, '0);
    exp_q.push_back({1'b0, 32'h0000CAFE});
    smp();
    cyc();
    cmd(1'b1, 1'b1, 32'h24, 32'h55);
    exp_q.push_back({1'b0, 32'h0});
    smp();
    check("ws_ready_in", 32'(cmd_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmd(1'b0, 1'b0, '0, '0);
      bus(1'b0, 1'b0, 32'hBAD0BAD0);
      smp();
      check("ws_htrans_held", 32'(HTRANS), 32'h2);
      check("ws_haddr_held", HADDR, 32'h24);
      check("ws_ready_low", 32'(cmd_ready), 32'h0);
      check("ws_no_rsp", 32'(rsp_valid), 32'h0);
    end
    cyc();
    bus(1'b1, 1'b0, 32'h0000CAFE);
    smp();
    check("ws_release_ready", 32'(cmd_ready), 32'h1);
    cyc();
    bus(1'b1, 1'b0, 32'hDEADBEEF);
    smp();
    check("ws_hwdata", HWDATA, 32'h55);
    check("ws_rsp_read", 32'(rsp_valid), 32'h1);
    cyc();
    bus(1'b1, 1'b0, 32'h0);
    smp();
    check("ws_rsp_write", 32'(rsp_valid), 32'h1);

    // Write gets ERROR while a read waits in its address phase
    cyc();
    cmd(1'b1, 1'b1, 32'h10, 32'h77);
    exp_q.push_back({1'b1, 32'h0});
    smp();
    cyc();
    cmd(1'b1, 1'b0, 32'h14, '0);
    exp_q.push_back({1'b0, 32'h0000600D});
    smp();
    check("er_haddr_w", HADDR, 32'h10);
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    bus(1'b0, 1'b1, 32'h0);
    smp();
    check("er1_htrans", 32'(HTRANS), 32'h2);
    check("er1_haddr", HADDR, 32'h14);
    check("er1_ready", 32'(cmd_ready), 32'h0);
    cyc();
    bus(1'b1, 1'b1, 32'h0);
    smp();
    check("er2_htrans_idle", 32'(HTRANS), 32'h0);
    check("er2_ready", 32'(cmd_ready), 32'h0);
    cyc();
    bus(1'b1, 1'b0, 32'h0);
    smp();
    check("er_reissue_htrans", 32'(HTRANS), 32'h2);
    check("er_reissue_haddr", HADDR, 32'h14);
    check("er_reissue_hwrite", 32'(HWRITE), 32'h0);
    check("er_rsp_write", 32'(rsp_valid), 32'h1);
    cyc();
    bus(1'b1, 1'b0, 32'h0000600D);
    smp();
    check("er_single_issue", 32'(HTRANS), 32'h0);
    cyc();
    bus(1'b1, 1'b0, 32'h0);
    smp();
    check("er_rsp_read", 32'(rsp_valid), 32'h1);

    // Reset during a data-phase wait state; the in-flight read yields no response
    cyc();
    cmd(1'b1, 1'b0, 32'h30, '0);
    smp();
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    smp();
    cyc();
    bus(1'b0, 1'b0, 32'h0);
    smp();
    cyc();
    #2;
    HRESETn = 1'b0;
    #1;
    check("rs_htrans", 32'(HTRANS), 32'h0);
    check("rs_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rs_haddr", HADDR, 32'h0);
    check("rs_ready", 32'(cmd_ready), 32'h1);
    smp();
    cyc();
    HRESETn = 1'b1;
    bus(1'b1, 1'b0, 32'h0);
    cmd(1'b1, 1'b0, 32'h40, '0);
    exp_q.push_back({1'b0, 32'h00004242});
    smp();
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    smp();
    check("rs_new_htrans", 32'(HTRANS), 32'h2);
    check("rs_new_haddr", HADDR, 32'h40);
    cyc();
    bus(1'b1, 1'b0, 32'h00004242);
    smp();
    cyc();
    bus(1'b1, 1'b0, 32'h0);
    smp();
    check("rs_new_rsp", 32'(rsp_valid), 32'h1);

`ifdef AHB_INITIATOR_TIMEOUT_EN
    // Stalled data phase locks the block after 8 wait cycles
    cyc();
    cmd(1'b1, 1'b0, 32'h50, '0);
    exp_q.push_back({1'b1, 32'h0});
    smp();
    cyc();
    cmd(1'b1, 1'b1, 32'h54, 32'h99);
    smp();
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    bus(1'b0, 1'b0, 32'hFFFFFFFF);
    smp();
    check("to_ready_wait", 32'(cmd_ready), 32'h0);
    check("to_not_yet0", 32'(timeout), 32'h0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      smp();
      check("to_not_yet", 32'(timeout), 32'h0);
      check("to_no_rsp", 32'(rsp_valid), 32'h0);
    end
    cyc();
    smp();
    check("to_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to_timeout", 32'(timeout), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmd(1'b1, 1'b0, 32'h60, '0);
      bus(1'b1, 1'b0, 32'h0);
      smp();
      check("lk_ready", 32'(cmd_ready), 32'h0);
      check("lk_htrans", 32'(HTRANS), 32'h0);
      check("lk_timeout", 32'(timeout), 32'h1);
    end
    cyc();
    cmd(1'b0, 1'b0, '0, '0);
    HRESETn = 1'b0;
    smp();
    check("lk_reset_timeout", 32'(timeout), 32'h0);
    check("lk_reset_ready", 32'(cmd_ready), 32'h1);
    cyc();
    HRESETn = 1'b1;
`endif

    repeat (3) cyc();
    check("rsp_outstanding", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_initiator.md
Name: ahb_lite_initiator

Overview:
- AHB-Lite bus master that converts a simple valid/ready command stream into single NONSEQ transfers on the system bus.
- Sits between a local controller (test sequencer, bridge or CPU-less DMA) and the AHB-Lite interconnect, and drives slaves such as the GPIO and memory blocks.
- Supports pipelined back-to-back transfers, HREADY wait states and the two-cycle HRESP error response, returning one response per command.

Parameters:
- ADDR_W, 32, HADDR and cmd_addr width.
- DATA_W, 32, HWDATA/HRDATA and cmd_wdata/rsp_rdata width.
- TIMEOUT_CYCLES, 256, consecutive data-phase wait states before timeout (used only with the optional feature).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address (word aligned).
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  transfer ended with HRESP ERROR or timeout.
- HADDR  out  ADDR_W  address.
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWRITE  out  1  direction.
- HSIZE  out  3  constant 3'b010 (word).
- HWDATA  out  DATA_W  write data in data phase.
- HREADY  in  1  transfer-done / bus ready from the interconnect.
- HRDATA  in  DATA_W  read data.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async assert, sync release): HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, both phase registers empty, cmd_ready=1.
- Two register stages:
  - AP holds the command in its address phase; it drives HADDR, HWRITE and HTRANS=NONSEQ.
  - DP holds the command in its data phase, plus write data; HWDATA = DP data and is held stable through wait states.
- cmd_ready = !AP.valid || (HREADY && !HRESP).
- On accept, the command loads into AP. It is visible on the bus the cycle after the accept edge, so latency from accept to first NONSEQ is 1 cycle.
- At an edge with HREADY=1: AP moves to DP, and the old DP completes.
- Back-to-back commands give NONSEQ on consecutive cycles with no IDLE gap.
- With AP empty, HTRANS=IDLE and HADDR/HWRITE hold their last values.
- Completion: rsp_valid=1 for exactly the cycle after the completing edge.
  - Read: rsp_rdata = HRDATA sampled at that edge.
  - Write: rsp_rdata = 0.
  - rsp_err = HRESP sampled at that edge.
- Wait states (HREADY=0, HRESP=0): AP and DP hold; bus outputs are unchanged; cmd_ready=0 if AP is valid.
- Error, first cycle (DP valid, HRESP=1, HREADY=0):
  - The next cycle drives HTRANS=IDLE, cancelling AP on the bus while keeping it internally.
  - cmd_ready=0.
- Error, second cycle (HRESP=1, HREADY=1): DP completes with rsp_err=1. The retained AP command is reissued as NONSEQ on the following cycle; it is never dropped or duplicated.
- Responses are returned in command order; at most 2 commands are outstanding (AP + DP).
- Reset mid-transfer: all in-flight commands are discarded and no response is issued; bus outputs return to reset values immediately.
- HRESP=1 with DP empty is a protocol violation from the slave. The block ignores it, but the bench flags it.

Optional Feature:
- Macro: AHB_INITIATOR_TIMEOUT_EN.
- With it defined:
  - A counter tracks consecutive HREADY=0 cycles while DP is valid; it clears on HREADY=1.
  - At TIMEOUT_CYCLES the block forces DP completion with rsp_valid=1, rsp_err=1, rsp_rdata=0, and enters LOCKED.
  - In LOCKED: HTRANS=IDLE, cmd_ready=0, AP is discarded. Only HRESETn exits LOCKED.
  - Adds output port timeout (1 bit), sticky high in LOCKED, reset 0.
- Without it: no counter, no LOCKED state, no timeout port; the block waits indefinitely on HREADY.

Test Plan:
- Single write, cmd_addr=0x00000004, wdata=0x00000001, HREADY tied 1:
  - HTRANS=NONSEQ, HWRITE=1, HADDR=0x4 one cycle after accept.
  - HWDATA=0x1 the next cycle.
  - rsp_valid the cycle after that with rsp_err=0.
- Three back-to-back reads 0x0/0x4/0x8, slave returns 0xA5A5, 0x0001, 0x1234 with no wait states → three consecutive NONSEQ cycles, three consecutive rsp_valid pulses in order with matching rsp_rdata.
- Read with 3 wait states (HREADY=0 x3) and a write queued behind it:
  - HADDR and HTRANS for the queued write are held.
  - cmd_ready=0 for those cycles.
  - One rsp_valid per command, in order.
- Write to 0x10 gets an ERROR response while a read to 0x14 is in its address phase:
  - HTRANS=IDLE on the cycle after the first error cycle.
  - Write completes with rsp_err=1.
  - Read to 0x14 is reissued as NONSEQ and completes with rsp_err=0.
- HRESETn asserted during a data-phase wait state → same cycle HTRANS=IDLE and rsp_valid=0; after release the first new command completes normally.
- With AHB_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES=8, HREADY held 0:
  - After 8 wait cycles: rsp_err=1 and timeout=1.
  - cmd_ready stays 0 until reset.
